// File: rtl/gray_code_counter_if.sv
// Counter control and count-output bundle shared by the counter and its driver.
// Latency: none (wires only). Backpressure: none; outputs are valid every cycle.
// The master drives step/load controls; the slave (counter) returns the count.
interface gray_code_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             wrap;

    modport master (
        output en,
        output up,
        output load,
        output load_bin,
        input  bin_out,
        input  gray_out,
        input  wrap
    );

    modport slave (
        input  en,
        input  up,
        input  load,
        input  load_bin,
        output bin_out,
        output gray_out,
        output wrap
    );
endinterface

// File: rtl/gray_code_counter.sv
// Up/down binary counter with a registered Gray-coded copy and a wrap pulse.
// Latency: one cycle from en/load to bin_out, gray_out and wrap together.
// Backpressure: none; a step is taken on every cycle en is high.
module gray_code_counter #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    gray_code_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    always_comb begin
        bin_next  = bin_q;
        wrap_next = 1'b0;
        if (bus.load) begin
            bin_next = bus.load_bin;
        end else if (bus.en) begin
            if (bus.up) begin
                bin_next  = bin_q + ONE;
                wrap_next = &bin_q;
            end else begin
                bin_next  = bin_q - ONE;
                wrap_next = ~|bin_q;
            end
        end
    end

    // Encode the value about to be registered so binary and Gray stay aligned.
    assign gray_next = bin_next ^ (bin_next >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= gray_next;
            wrap_q <= wrap_next;
        end
    end

    assign bus.bin_out  = bin_q;
    assign bus.gray_out = gray_q;
    assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_gray_code_counter.sv
// Scoreboard bench: the driver pushes model predictions, the monitor pops and compares.
module tb_gray_code_counter;
    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    typedef struct {
        int bin;
        int gray;
        int wrap;
        bit step;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_cnt = 0;
    logic [W-1:0] prev_gray;
    bit   have_prev = 0;

    gray_code_counter_if #(.WIDTH(W)) bus ();

    gray_code_counter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int to_gray(int n);
        return n ^ (n >> 1);
    endfunction

    function automatic int from_gray(logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return int'(b);
    endfunction

    function automatic void check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endfunction

    // Drive one cycle of inputs and queue what the outputs must show after the edge.
    task automatic cycle(input bit r, input bit e, input bit u, input bit ld, input int lb);
        exp_t x;
        @(negedge clk);
        rst          = r;
        bus.en       = e;
        bus.up       = u;
        bus.load     = ld;
        bus.load_bin = W'(lb);
        x.wrap = 0;
        x.step = 0;
        if (r) begin
            model_cnt = 0;
        end else if (ld) begin
            model_cnt = lb & MAX;
        end else if (e) begin
            x.step = 1;
            if (u) begin
                x.wrap    = (model_cnt == MAX) ? 1 : 0;
                model_cnt = (model_cnt + 1) % (MAX + 1);
            end else begin
                x.wrap    = (model_cnt == 0) ? 1 : 0;
                model_cnt = (model_cnt + MAX) % (MAX + 1);
            end
        end
        x.bin  = model_cnt;
        x.gray = to_gray(model_cnt);
        sb.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("bin_out", int'(bus.bin_out), e.bin);
            check("gray_out", int'(bus.gray_out), e.gray);
            check("wrap", int'(bus.wrap), e.wrap);
            check("gtob_loopback", from_gray(bus.gray_out), e.bin);
            if (e.step && have_prev)
                check("gray_onebit", $countones(bus.gray_out ^ prev_gray), 1);
            prev_gray = bus.gray_out;
            have_prev = 1;
        end
    end

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.up = 1'b0;
        bus.load = 1'b0;
        bus.load_bin = '0;

        // Reset then a full up sweep including the wrap back to zero
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 9);
        for (int i = 0; i < 16; i++) cycle(0, 1, 1, 0, $urandom);
        cycle(0, 1, 1, 0, 0);

        // Down from zero, then one more down step
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);

        // Load wins over en; second load
        cycle(0, 1, 1, 1, 'b1010);
        cycle(0, 1, 0, 1, 'b0111);

        // Hold with junk on up/load_bin, then up and down
        cycle(0, 0, 0, 1, 'b0101);
        for (int i = 0; i < 3; i++) cycle(0, 0, $urandom_range(1), 0, $urandom);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);

        // Reset dominates a simultaneous load mid-count
        cycle(0, 0, 0, 1, 'b1000);
        cycle(0, 1, 1, 0, 0);
        cycle(1, 1, 1, 1, 'b1111);

        // Full down sweep with loopback decoding on every cycle
        for (int i = 0; i < 17; i++) cycle(0, 1, 0, 0, 0);

        // Loads at both extremes followed by the wrapping step
        cycle(0, 0, 0, 1, MAX);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            int p;
            p = $urandom_range(99);
            cycle((p < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(99) < 75) ? 1'b1 : 1'b0,
                  $urandom_range(1),
                  (p >= 2 && p < 10) ? 1'b1 : 1'b0,
                  $urandom);
        end

        @(negedge clk);
        bus.en = 1'b0;
        bus.load = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gray_code_counter.md
Name: gray_code_counter

Overview:
Binary-to-Gray direction of the team's Gray-code path: an up/down counter that keeps a binary count and publishes a registered Gray-coded copy of it every cycle. It produces single-bit-change pointers, for example for FIFO read/write pointers, which the existing gtob decoder converts back to binary on the far side. The counter supports a synchronous load and a terminal wrap indication.

Parameters:
WIDTH, 4, counter width in bits for bin_out, gray_out and load_bin; legal values are 2 to 16.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  advance the count by one step this cycle
up  input  1  step direction, sampled with en: 1 = increment, 0 = decrement
load  input  1  synchronous load of load_bin, with priority over en
load_bin  input  WIDTH  binary value to load
bin_out  output  WIDTH  registered binary count
gray_out  output  WIDTH  registered Gray code of bin_out
wrap  output  1  one-cycle pulse indicating the last step wrapped

Behaviour:
- One clock and one reset: clk, plus rst, which is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values: bin_out = 0, gray_out = 0, wrap = 0. If rst is asserted mid-count, the next edge forces all three to 0 regardless of en or load.
- Priority at each edge: rst, then load, then en, then hold.
- Load:
  - bin_out <= load_bin.
  - gray_out <= load_bin ^ (load_bin >> 1).
  - wrap <= 0.
  - en and up are ignored in the same cycle.
- Step (en=1, load=0):
  - bin_next = bin_out + 1 when up=1; bin_next = bin_out - 1 when up=0.
  - Arithmetic is modulo 2^WIDTH.
- Gray encoding: gray_out <= bin_next ^ (bin_next >> 1), computed from the next binary value, not the current one.
  - Consequence: bin_out and gray_out always describe the same count in the same cycle, with one cycle of latency from en.
  - No combinational path from inputs to outputs.
- Single-bit change: every en step changes exactly one bit of gray_out, including the wrap steps 2^WIDTH-1 -> 0 and 0 -> 2^WIDTH-1. A load may change any number of bits.
- wrap:
  - Registered; asserted for exactly the cycle following a step where up=1 and bin_out = 2^WIDTH-1, or up=0 and bin_out = 0.
  - Otherwise 0 on every edge, including hold cycles and load cycles.
- Hold (en=0, load=0): bin_out and gray_out keep their values, and wrap <= 0.
- Direction may change on any cycle. There is no restriction on toggling up between consecutive steps.
- X handling: up and load_bin are don't-care when their qualifying enable is low.

Test Plan:
1. Reset then count up: rst=1 for 2 cycles, then en=1, up=1 for 16 cycles (WIDTH=4).
   - gray_out must step 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000.
   - wrap=1 only in the cycle gray_out returns to 0000.
   - Every transition changes exactly 1 bit, checked with $countones of the XOR.
2. Down from zero: after reset, apply en=1, up=0 for 1 cycle.
   - Required: bin_out=1111, gray_out=1000, wrap=1.
   - One further down step gives bin_out=1110, gray_out=1001, wrap=0.
3. Load priority:
   - load=1, load_bin=1010, en=1, up=1 gives bin_out=1010, gray_out=1111, wrap=0 (not 1011).
   - Then load_bin=0111 gives gray_out=0100.
4. Hold and direction change:
   - From bin_out=0101 (gray 0111), en=0 for 3 cycles: outputs unchanged, wrap=0.
   - Then up then down steps give gray 0101 (bin 0110) and then back to 0111 (bin 0101).
5. Reset mid-operation: while counting up at bin_out=1001, assert rst together with load=1, load_bin=1111.
   - Next edge: bin_out=0000, gray_out=0000, wrap=0.
6. Loopback: drive gray_out into gtob across a full up sweep and a full down sweep.
   - Decoded output must equal bin_out on every cycle.
